// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers with memory stall, EX/MEM flush and sticky halt.
// Optional retire/stall counters are enabled by defining PIPE_PERF_CNT_EN.
module ex_mem_wb_pipe #(
  parameter int unsigned DW = 16,
  parameter int unsigned RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_stall,
  input  logic          exmem_flush,
  input  logic          ex_valid,
  input  logic          ex_reg_write,
  input  logic          ex_mem_write,
  input  logic          ex_mem_read,
  input  logic          ex_mem_to_reg,
  input  logic          ex_halt,
  input  logic [RW-1:0] ex_write_reg,
  input  logic [RW-1:0] ex_rt,
  input  logic [DW-1:0] ex_alu_result,
  input  logic [DW-1:0] ex_store_data,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mtom,
  output logic          exmem_valid,
  output logic          exmem_reg_write,
  output logic          exmem_mem_write,
  output logic          exmem_mem_read,
  output logic          exmem_mem_to_reg,
  output logic          exmem_halt,
  output logic [RW-1:0] exmem_write_reg,
  output logic [RW-1:0] exmem_rt,
  output logic [DW-1:0] exmem_alu_result,
  output logic [DW-1:0] exmem_store_data,
  output logic [DW-1:0] exmem_store_fwd,
  output logic          memwb_valid,
  output logic          memwb_reg_write,
  output logic          memwb_halt,
  output logic [RW-1:0] memwb_write_reg,
  output logic [DW-1:0] memwb_wdata,
  output logic          halted
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [15:0]   retire_cnt,
  output logic [15:0]   stall_cnt
`endif
);

  logic          exmem_valid_q, exmem_valid_d;
  logic          exmem_reg_write_q, exmem_reg_write_d;
  logic          exmem_mem_write_q, exmem_mem_write_d;
  logic          exmem_mem_read_q, exmem_mem_read_d;
  logic          exmem_mem_to_reg_q, exmem_mem_to_reg_d;
  logic          exmem_halt_q, exmem_halt_d;
  logic [RW-1:0] exmem_write_reg_q, exmem_write_reg_d;
  logic [RW-1:0] exmem_rt_q, exmem_rt_d;
  logic [DW-1:0] exmem_alu_result_q, exmem_alu_result_d;
  logic [DW-1:0] exmem_store_data_q, exmem_store_data_d;
  logic          memwb_valid_q, memwb_valid_d;
  logic          memwb_reg_write_q, memwb_reg_write_d;
  logic          memwb_halt_q, memwb_halt_d;
  logic [RW-1:0] memwb_write_reg_q, memwb_write_reg_d;
  logic [DW-1:0] memwb_wdata_q, memwb_wdata_d;
  logic          halted_q, halted_d;
  logic          mem_load;
  logic          halt_arrive;

  // Next-state for both stages; default is hold, bubbles only clear control bits.
  always_comb begin
    exmem_valid_d      = exmem_valid_q;
    exmem_reg_write_d  = exmem_reg_write_q;
    exmem_mem_write_d  = exmem_mem_write_q;
    exmem_mem_read_d   = exmem_mem_read_q;
    exmem_mem_to_reg_d = exmem_mem_to_reg_q;
    exmem_halt_d       = exmem_halt_q;
    exmem_write_reg_d  = exmem_write_reg_q;
    exmem_rt_d         = exmem_rt_q;
    exmem_alu_result_d = exmem_alu_result_q;
    exmem_store_data_d = exmem_store_data_q;
    memwb_valid_d      = memwb_valid_q;
    memwb_reg_write_d  = memwb_reg_write_q;
    memwb_halt_d       = memwb_halt_q;
    memwb_write_reg_d  = memwb_write_reg_q;
    memwb_wdata_d      = memwb_wdata_q;
    mem_load           = ~halted_q & ~mem_stall;
    halt_arrive        = mem_load & exmem_valid_q & exmem_halt_q;
    halted_d           = halted_q | halt_arrive;

    if (halted_q) begin
      exmem_valid_d      = 1'b0;
      exmem_reg_write_d  = 1'b0;
      exmem_mem_write_d  = 1'b0;
      exmem_mem_read_d   = 1'b0;
      exmem_mem_to_reg_d = 1'b0;
      exmem_halt_d       = 1'b0;
      memwb_valid_d      = 1'b0;
      memwb_reg_write_d  = 1'b0;
      memwb_halt_d       = 1'b0;
    end else if (!mem_stall) begin
      memwb_valid_d     = exmem_valid_q;
      memwb_reg_write_d = exmem_reg_write_q & exmem_valid_q;
      memwb_halt_d      = exmem_halt_q & exmem_valid_q;
      memwb_write_reg_d = exmem_write_reg_q;
      memwb_wdata_d     = exmem_mem_to_reg_q ? mem_rdata : exmem_alu_result_q;
      // Flush, a HLT retiring ahead, or an invalid EX slot all become a bubble.
      if (exmem_flush || halt_arrive || !ex_valid) begin
        exmem_valid_d      = 1'b0;
        exmem_reg_write_d  = 1'b0;
        exmem_mem_write_d  = 1'b0;
        exmem_mem_read_d   = 1'b0;
        exmem_mem_to_reg_d = 1'b0;
        exmem_halt_d       = 1'b0;
      end else begin
        exmem_valid_d      = 1'b1;
        exmem_reg_write_d  = ex_reg_write & ex_valid;
        exmem_mem_write_d  = ex_mem_write & ex_valid;
        exmem_mem_read_d   = ex_mem_read & ex_valid;
        exmem_mem_to_reg_d = ex_mem_to_reg & ex_valid;
        exmem_halt_d       = ex_halt & ex_valid;
        exmem_write_reg_d  = ex_write_reg;
        exmem_rt_d         = ex_rt;
        exmem_alu_result_d = ex_alu_result;
        exmem_store_data_d = ex_store_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exmem_valid_q      <= 1'b0;
      exmem_reg_write_q  <= 1'b0;
      exmem_mem_write_q  <= 1'b0;
      exmem_mem_read_q   <= 1'b0;
      exmem_mem_to_reg_q <= 1'b0;
      exmem_halt_q       <= 1'b0;
      exmem_write_reg_q  <= '0;
      exmem_rt_q         <= '0;
      exmem_alu_result_q <= '0;
      exmem_store_data_q <= '0;
      memwb_valid_q      <= 1'b0;
      memwb_reg_write_q  <= 1'b0;
      memwb_halt_q       <= 1'b0;
      memwb_write_reg_q  <= '0;
      memwb_wdata_q      <= '0;
      halted_q           <= 1'b0;
    end else begin
      exmem_valid_q      <= exmem_valid_d;
      exmem_reg_write_q  <= exmem_reg_write_d;
      exmem_mem_write_q  <= exmem_mem_write_d;
      exmem_mem_read_q   <= exmem_mem_read_d;
      exmem_mem_to_reg_q <= exmem_mem_to_reg_d;
      exmem_halt_q       <= exmem_halt_d;
      exmem_write_reg_q  <= exmem_write_reg_d;
      exmem_rt_q         <= exmem_rt_d;
      exmem_alu_result_q <= exmem_alu_result_d;
      exmem_store_data_q <= exmem_store_data_d;
      memwb_valid_q      <= memwb_valid_d;
      memwb_reg_write_q  <= memwb_reg_write_d;
      memwb_halt_q       <= memwb_halt_d;
      memwb_write_reg_q  <= memwb_write_reg_d;
      memwb_wdata_q      <= memwb_wdata_d;
      halted_q           <= halted_d;
    end
  end

  assign exmem_valid      = exmem_valid_q;
  assign exmem_reg_write  = exmem_reg_write_q;
  assign exmem_mem_write  = exmem_mem_write_q;
  assign exmem_mem_read   = exmem_mem_read_q;
  assign exmem_mem_to_reg = exmem_mem_to_reg_q;
  assign exmem_halt       = exmem_halt_q;
  assign exmem_write_reg  = exmem_write_reg_q;
  assign exmem_rt         = exmem_rt_q;
  assign exmem_alu_result = exmem_alu_result_q;
  assign exmem_store_data = exmem_store_data_q;
  assign memwb_valid      = memwb_valid_q;
  assign memwb_reg_write  = memwb_reg_write_q;
  assign memwb_halt       = memwb_halt_q;
  assign memwb_write_reg  = memwb_write_reg_q;
  assign memwb_wdata      = memwb_wdata_q;
  assign halted           = halted_q;

  // MtoM forwarding of a just-loaded value into the store path.
  assign exmem_store_fwd = mtom ? memwb_wdata_q : exmem_store_data_q;

`ifdef PIPE_PERF_CNT_EN
  localparam int unsigned CW = 16;
  logic [CW-1:0] retire_cnt_q, retire_cnt_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating counters keyed to MEM/WB load edges and live stall cycles.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (mem_load && exmem_valid_q && (retire_cnt_q != {CW{1'b1}})) begin
      retire_cnt_d = retire_cnt_q + CW'(1);
    end
    if (mem_stall && !halted_q && (stall_cnt_q != {CW{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Self-checking bench for ex_mem_wb_pipe: directed scenarios plus randomized traffic
// checked against a transaction-level model of the two pipeline stages.
module tb_ex_mem_wb_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_stall, exmem_flush, ex_valid, ex_reg_write, ex_mem_write;
  logic        ex_mem_read, ex_mem_to_reg, ex_halt, mtom;
  logic [3:0]  ex_write_reg, ex_rt;
  logic [15:0] ex_alu_result, ex_store_data, mem_rdata;
  logic        exmem_valid, exmem_reg_write, exmem_mem_write, exmem_mem_read;
  logic        exmem_mem_to_reg, exmem_halt;
  logic [3:0]  exmem_write_reg, exmem_rt, memwb_write_reg;
  logic [15:0] exmem_alu_result, exmem_store_data, exmem_store_fwd, memwb_wdata;
  logic        memwb_valid, memwb_reg_write, memwb_halt, halted;
`ifdef PIPE_PERF_CNT_EN
  logic [15:0] retire_cnt, stall_cnt;
`endif

  ex_mem_wb_pipe dut (
    .clk(clk), .rst_n(rst_n), .mem_stall(mem_stall), .exmem_flush(exmem_flush),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write),
    .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg), .ex_halt(ex_halt),
    .ex_write_reg(ex_write_reg), .ex_rt(ex_rt), .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data), .mem_rdata(mem_rdata), .mtom(mtom),
    .exmem_valid(exmem_valid), .exmem_reg_write(exmem_reg_write),
    .exmem_mem_write(exmem_mem_write), .exmem_mem_read(exmem_mem_read),
    .exmem_mem_to_reg(exmem_mem_to_reg), .exmem_halt(exmem_halt),
    .exmem_write_reg(exmem_write_reg), .exmem_rt(exmem_rt),
    .exmem_alu_result(exmem_alu_result), .exmem_store_data(exmem_store_data),
    .exmem_store_fwd(exmem_store_fwd), .memwb_valid(memwb_valid),
    .memwb_reg_write(memwb_reg_write), .memwb_halt(memwb_halt),
    .memwb_write_reg(memwb_write_reg), .memwb_wdata(memwb_wdata), .halted(halted)
`ifdef PIPE_PERF_CNT_EN
    , .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Instruction-level view of what each stage holds.
  typedef struct {
    logic v, rw, mw, mr, m2r, h;
    logic [3:0] wr, rt;
    logic [15:0] alu, sd;
  } em_t;
  typedef struct {
    logic v, rw, h;
    logic [3:0] wr;
    logic [15:0] wd;
  } wb_t;

  em_t         em;
  wb_t         wb;
  logic        mh;
  int unsigned m_ret, m_stl;
  int          vectors = 0;
  int          errors = 0;

  task automatic model_reset();
    em = '{default: '0};
    wb = '{default: '0};
    mh = 1'b0;
    m_ret = 0;
    m_stl = 0;
  endtask

  // One clock edge of the pipeline as an instruction-movement model.
  task automatic model_edge();
    em_t  nem;
    wb_t  nwb;
    logic moving, arrive;
    nem = em;
    nwb = wb;
    moving = !mh && !mem_stall;
    arrive = moving && em.v && em.h;
    if (mh) begin
      {nem.v, nem.rw, nem.mw, nem.mr, nem.m2r, nem.h} = '0;
      {nwb.v, nwb.rw, nwb.h} = '0;
    end else if (moving) begin
      nwb.v  = em.v;
      nwb.rw = em.rw;
      nwb.h  = em.h;
      nwb.wr = em.wr;
      nwb.wd = em.m2r ? mem_rdata : em.alu;
      if (exmem_flush || arrive || !ex_valid)
        {nem.v, nem.rw, nem.mw, nem.mr, nem.m2r, nem.h} = '0;
      else
        nem = '{1'b1, ex_reg_write, ex_mem_write, ex_mem_read, ex_mem_to_reg, ex_halt,
                ex_write_reg, ex_rt, ex_alu_result, ex_store_data};
    end
    if (moving && em.v && m_ret < 65535) m_ret++;
    if (mem_stall && !mh && m_stl < 65535) m_stl++;
    mh = mh || arrive;
    em = nem;
    wb = nwb;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_idle();
    mem_stall = 0; exmem_flush = 0; ex_valid = 0; ex_reg_write = 0; ex_mem_write = 0;
    ex_mem_read = 0; ex_mem_to_reg = 0; ex_halt = 0; mtom = 0;
    ex_write_reg = '0; ex_rt = '0; ex_alu_result = '0; ex_store_data = '0; mem_rdata = '0;
  endtask

  task automatic hard_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    logic [85:0] act;
    set_idle();
    ex_valid = 1; ex_reg_write = 1; ex_write_reg = 4'd9; ex_alu_result = 16'hA5A5;
    tick();
    tick();
    #1 rst_n = 1'b0;
    #1;
    act = {exmem_valid, exmem_reg_write, exmem_mem_write, exmem_mem_read, exmem_mem_to_reg,
           exmem_halt, exmem_write_reg, exmem_rt, exmem_alu_result, exmem_store_data,
           memwb_valid, memwb_reg_write, memwb_halt, memwb_write_reg, memwb_wdata, halted,
           exmem_store_fwd};
    vectors++;
    if (act !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", act);
    end
`ifdef PIPE_PERF_CNT_EN
    vectors++;
    if ({retire_cnt, stall_cnt} !== 32'd0) begin
      errors++;
      $display("FAIL reset_counters: got %h expected 0", {retire_cnt, stall_cnt});
    end
`endif
    #2 rst_n = 1'b1;
    model_reset();
    set_idle();
    @(negedge clk);
  endtask

  task automatic test_alu_pass();
    set_idle();
    ex_valid = 1; ex_reg_write = 1; ex_write_reg = 4'd3; ex_alu_result = 16'h0042;
    tick();
    vectors++;
    if (exmem_write_reg !== 4'd3 || exmem_reg_write !== 1'b1 || exmem_valid !== 1'b1) begin
      errors++;
      $display("FAIL add_exmem: wr=%0d rw=%b v=%b expected wr=3 rw=1 v=1",
               exmem_write_reg, exmem_reg_write, exmem_valid);
    end
    set_idle();
    tick();
    vectors++;
    if (memwb_wdata !== 16'h0042 || memwb_reg_write !== 1'b1 || memwb_write_reg !== 4'd3) begin
      errors++;
      $display("FAIL add_memwb: wd=%h rw=%b wr=%0d expected 0042 1 3",
               memwb_wdata, memwb_reg_write, memwb_write_reg);
    end
    vectors++;
    if (exmem_valid !== 1'b0) begin
      errors++;
      $display("FAIL nop_exmem_valid: got %b expected 0", exmem_valid);
    end
  endtask

  task automatic test_load_stall();
    set_idle();
    ex_valid = 1; ex_reg_write = 1; ex_mem_read = 1; ex_mem_to_reg = 1;
    ex_write_reg = 4'd5; ex_alu_result = 16'h0100;
    tick();
    set_idle();
    mem_stall = 1; mem_rdata = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (exmem_valid !== 1'b1 || exmem_write_reg !== 4'd5 || exmem_mem_to_reg !== 1'b1 ||
          memwb_valid !== 1'b0 || memwb_wdata !== 16'h0042) begin
        errors++;
        $display("FAIL stall_hold[%0d]: em_v=%b em_wr=%0d m2r=%b wb_v=%b wd=%h expected 1 5 1 0 0042",
                 i, exmem_valid, exmem_write_reg, exmem_mem_to_reg, memwb_valid, memwb_wdata);
      end
    end
    mem_stall = 0;
    tick();
    vectors++;
    if (memwb_wdata !== 16'hBEEF || memwb_valid !== 1'b1 || memwb_write_reg !== 4'd5) begin
      errors++;
      $display("FAIL load_after_stall: wd=%h v=%b wr=%0d expected BEEF 1 5",
               memwb_wdata, memwb_valid, memwb_write_reg);
    end
`ifdef PIPE_PERF_CNT_EN
    vectors++;
    if (stall_cnt !== 16'(m_stl)) begin
      errors++;
      $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt, m_stl);
    end
`endif
  endtask

  task automatic test_flush();
    set_idle();
    ex_valid = 1; ex_reg_write = 1; ex_write_reg = 4'd6; ex_alu_result = 16'h0777;
    tick();
    set_idle();
    ex_valid = 1; ex_mem_write = 1; exmem_flush = 1; mem_stall = 1;
    tick();
    vectors++;
    if (exmem_valid !== 1'b1 || exmem_write_reg !== 4'd6 || exmem_mem_write !== 1'b0) begin
      errors++;
      $display("FAIL flush_during_stall: v=%b wr=%0d mw=%b expected 1 6 0",
               exmem_valid, exmem_write_reg, exmem_mem_write);
    end
    mem_stall = 0;
    tick();
    vectors++;
    if (exmem_valid !== 1'b0 || exmem_reg_write !== 1'b0 || exmem_mem_write !== 1'b0) begin
      errors++;
      $display("FAIL flush_bubble: v=%b rw=%b mw=%b expected 0 0 0",
               exmem_valid, exmem_reg_write, exmem_mem_write);
    end
    vectors++;
    if (memwb_valid !== 1'b1 || memwb_wdata !== 16'h0777) begin
      errors++;
      $display("FAIL flush_memwb_loads: v=%b wd=%h expected 1 0777", memwb_valid, memwb_wdata);
    end
  endtask

  task automatic test_mtom();
    set_idle();
    ex_valid = 1; ex_reg_write = 1; ex_mem_read = 1; ex_mem_to_reg = 1;
    ex_write_reg = 4'd4; ex_alu_result = 16'h0010;
    tick();
    set_idle();
    ex_valid = 1; ex_mem_write = 1; ex_rt = 4'd4; ex_store_data = 16'h0000;
    ex_alu_result = 16'h0020; mem_rdata = 16'h1234;
    tick();
    set_idle();
    mtom = 1;
    #1;
    vectors++;
    if (exmem_store_fwd !== 16'h1234 || exmem_store_data !== 16'h0000 || exmem_rt !== 4'd4) begin
      errors++;
      $display("FAIL mtom_sel: fwd=%h sd=%h rt=%0d expected 1234 0000 4",
               exmem_store_fwd, exmem_store_data, exmem_rt);
    end
    mtom = 0;
    #1;
    vectors++;
    if (exmem_store_fwd !== 16'h0000) begin
      errors++;
      $display("FAIL mtom_off: fwd=%h expected 0000", exmem_store_fwd);
    end
    @(negedge clk);
  endtask

  task automatic test_halt();
    hard_reset();
    set_idle();
    @(negedge clk);
    ex_valid = 1; ex_halt = 1;
    tick();
    set_idle();
    ex_valid = 1; ex_reg_write = 1; ex_write_reg = 4'd7; ex_alu_result = 16'h0009;
    tick();
    vectors++;
    if (halted !== 1'b1 || memwb_halt !== 1'b1 || memwb_valid !== 1'b1 || exmem_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_arrive: halted=%b wb_h=%b wb_v=%b em_v=%b expected 1 1 1 0",
               halted, memwb_halt, memwb_valid, exmem_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (halted !== 1'b1 || memwb_valid !== 1'b0 || exmem_valid !== 1'b0) begin
        errors++;
        $display("FAIL halt_sticky[%0d]: halted=%b wb_v=%b em_v=%b expected 1 0 0",
                 i, halted, memwb_valid, exmem_valid);
      end
    end
`ifdef PIPE_PERF_CNT_EN
    vectors++;
    if (retire_cnt !== 16'd1) begin
      errors++;
      $display("FAIL halt_retire_cnt: got %0d expected 1", retire_cnt);
    end
`endif
    set_idle();
  endtask

  task automatic test_random();
    logic [85:0] act, exp;
    for (int r = 0; r < 6; r++) begin
      hard_reset();
      for (int c = 0; c < 80; c++) begin
        mem_stall     = ($urandom_range(3) == 0);
        exmem_flush   = ($urandom_range(9) == 0);
        ex_valid      = ($urandom_range(4) != 0);
        ex_reg_write  = 1'($urandom);
        ex_mem_write  = 1'($urandom);
        ex_mem_read   = 1'($urandom);
        ex_mem_to_reg = 1'($urandom);
        ex_halt       = ($urandom_range(59) == 0);
        ex_write_reg  = 4'($urandom);
        ex_rt         = 4'($urandom);
        ex_alu_result = 16'($urandom);
        ex_store_data = 16'($urandom);
        mem_rdata     = 16'($urandom);
        mtom          = 1'($urandom);
        tick();
        exp = {em.v, em.rw, em.mw, em.mr, em.m2r, em.h, em.wr, em.rt, em.alu, em.sd,
               wb.v, wb.rw, wb.h, wb.wr, wb.wd, mh, (mtom ? wb.wd : em.sd)};
        act = {exmem_valid, exmem_reg_write, exmem_mem_write, exmem_mem_read, exmem_mem_to_reg,
               exmem_halt, exmem_write_reg, exmem_rt, exmem_alu_result, exmem_store_data,
               memwb_valid, memwb_reg_write, memwb_halt, memwb_write_reg, memwb_wdata, halted,
               exmem_store_fwd};
        vectors++;
        if (act !== exp) begin
          errors++;
          $display("FAIL random r%0d c%0d: got %h expected %h", r, c, act, exp);
        end
`ifdef PIPE_PERF_CNT_EN
        vectors++;
        if (retire_cnt !== 16'(m_ret) || stall_cnt !== 16'(m_stl)) begin
          errors++;
          $display("FAIL random_cnt r%0d c%0d: got %0d/%0d expected %0d/%0d",
                   r, c, retire_cnt, stall_cnt, m_ret, m_stl);
        end
`endif
      end
    end
    set_idle();
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_alu_pass();
    test_load_stall();
    test_flush();
    test_mtom();
    test_halt();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
